// File: rtl/vga_text_writer.sv
// Console-style byte writer for the VGA text buffer: tracks an 80x30 cursor,
// interprets LF/CR/BS/FF, and blanks the screen or a single row with write bursts.
module vga_text_writer #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        wen,
    output logic [11:0] w_addr,
    output logic [7:0]  w_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam logic [11:0] COLS_W   = 12'(COLS);
    localparam logic [11:0] TOTAL_W  = 12'(COLS * ROWS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LINECLR
    } state_t;

    state_t      state_q;
    logic [11:0] cnt_q;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic        ready_q;
    logic        wen_q;
    logic [11:0] addr_q;
    logic [7:0]  data_q;

    logic [4:0]  row_nxt;
    logic [11:0] row_base;
    logic        is_ctrl;

    // The cursor row never exceeds ROWS-1, so row_base + col stays below COLS*ROWS.
    assign row_nxt  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign row_base = 12'(row_q) * COLS_W;
    assign is_ctrl  = (in_char < 8'h20) || (in_char == CH_DEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == TOTAL_W) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        wen_q  <= 1'b1;
                        addr_q <= cnt_q;
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + 12'd1;
                    end
                end
                S_LINECLR: begin
                    if (cnt_q == COLS_W) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        wen_q  <= 1'b1;
                        addr_q <= row_base + cnt_q;
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + 12'd1;
                    end
                end
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        case (in_char)
                            CH_LF: begin
                                col_q   <= '0;
                                row_q   <= row_nxt;
                                state_q <= S_LINECLR;
                                ready_q <= 1'b0;
                                cnt_q   <= '0;
                            end
                            CH_CR: col_q <= '0;
                            CH_BS: begin
                                if (col_q != 7'd0) begin
                                    col_q  <= col_q - 7'd1;
                                    wen_q  <= 1'b1;
                                    addr_q <= row_base + 12'(col_q) - 12'd1;
                                    data_q <= BLANK;
                                end
                            end
                            CH_FF: begin
                                col_q   <= '0;
                                row_q   <= '0;
                                state_q <= S_CLEAR;
                                ready_q <= 1'b0;
                                cnt_q   <= '0;
                            end
                            default: begin
                                if (!is_ctrl) begin
                                    wen_q  <= 1'b1;
                                    addr_q <= row_base + 12'(col_q);
                                    data_q <= in_char;
                                    if (col_q == LAST_COL) begin
                                        col_q   <= '0;
                                        row_q   <= row_nxt;
                                        state_q <= S_LINECLR;
                                        ready_q <= 1'b0;
                                        cnt_q   <= '0;
                                    end else begin
                                        col_q <= col_q + 7'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign wen        = wen_q;
    assign w_addr     = addr_q;
    assign w_data     = data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Randomized bench for vga_text_writer: a queue-based console model predicts
// every cycle's write strobe, address, data, ready and cursor.
module tb_vga_text_writer;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam int         TOTAL = COLS * ROWS;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        wen;
    logic [11:0] w_addr;
    logic [7:0]  w_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_col;
    int m_row;
    bit m_ready;
    bit m_wen;
    int m_addr;
    int m_data;
    int m_q[$];

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .wen        (wen),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void push_row(input int r);
        for (int c = 0; c < COLS; c++) m_q.push_back(r * COLS + c);
    endfunction

    function automatic void push_all();
        for (int a = 0; a < TOTAL; a++) m_q.push_back(a);
    endfunction

    function automatic void model_byte(input logic [7:0] c);
        case (c)
            8'h0A: begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                push_row(m_row);
                m_ready = 0;
            end
            8'h0D: m_col = 0;
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    m_wen  = 1;
                    m_addr = m_row * COLS + m_col;
                    m_data = BLANK;
                end
            end
            8'h0C: begin
                m_col = 0;
                m_row = 0;
                push_all();
                m_ready = 0;
            end
            default: begin
                if (c >= 8'h20 && c != 8'h7F) begin
                    m_wen  = 1;
                    m_addr = m_row * COLS + m_col;
                    m_data = c;
                    if (m_col == COLS - 1) begin
                        m_col = 0;
                        m_row = (m_row + 1) % ROWS;
                        push_row(m_row);
                        m_ready = 0;
                    end else begin
                        m_col++;
                    end
                end
            end
        endcase
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare #1 later.
    task automatic cycle(input bit r, input bit v, input logic [7:0] c);
        rst      = r;
        in_valid = v;
        in_char  = c;
        @(posedge clk);
        m_wen = 0;
        if (r) begin
            m_q.delete();
            m_col   = 0;
            m_row   = 0;
            m_ready = 0;
            push_all();
        end else if (m_q.size() > 0) begin
            m_wen  = 1;
            m_addr = m_q.pop_front();
            m_data = BLANK;
        end else if (!m_ready) begin
            m_ready = 1;
        end else if (v) begin
            model_byte(c);
        end
        #1;
        check("wen", 32'(wen), 32'(m_wen));
        if (m_wen) begin
            check("w_addr", 32'(w_addr), m_addr);
            check("w_data", 32'(w_data), m_data);
        end
        if (r) begin
            check("w_addr_rst", 32'(w_addr), 0);
            check("w_data_rst", 32'(w_data), 0);
        end
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("cursor_col", 32'(cursor_col), m_col);
        check("cursor_row", 32'(cursor_row), m_row);
    endtask

    function automatic logic [7:0] rand_byte(input bit heavy);
        int p;
        int x;
        logic [7:0] b;
        p = $urandom_range(0, 999);
        if (p < (heavy ? 600 : 950)) begin
            b = 8'($urandom_range(8'h20, 8'hFF));
            if (b == 8'h7F) b = 8'h41;
        end else if (p < (heavy ? 700 : 960)) b = 8'h0A;
        else if (p < (heavy ? 780 : 970)) b = 8'h0D;
        else if (p < (heavy ? 900 : 990)) b = 8'h08;
        else if (p < (heavy ? 903 : 991)) b = 8'h0C;
        else begin
            x = $urandom_range(0, 32);
            if (x == 32) b = 8'h7F;
            else if (x == 8 || x == 10 || x == 12 || x == 13) b = 8'h07;
            else b = 8'(x);
        end
        return b;
    endfunction

    task automatic run_until_ready(input int budget);
        int n;
        n = 0;
        while (!m_ready && n < budget) begin
            cycle(0, 0, 8'h00);
            n++;
        end
        check("ready_timeout", 32'(m_ready), 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        m_col    = 0;
        m_row    = 0;
        m_ready  = 0;

        cycle(1, 0, 8'h00);
        cycle(1, 0, 8'h00);
        run_until_ready(TOTAL + 10);

        // Back-to-back printable bytes
        cycle(0, 1, 8'h41);
        cycle(0, 1, 8'h42);
        cycle(0, 0, 8'h00);
        // CR, bell and backspace at column 0
        cycle(0, 1, 8'h0D);
        cycle(0, 1, 8'h07);
        cycle(0, 1, 8'h08);

        for (int i = 0; i < 20000; i++)
            cycle(0, $urandom_range(0, 3) != 0, rand_byte(1'b0));
        for (int i = 0; i < 15000; i++)
            cycle(0, $urandom_range(0, 3) != 0, rand_byte(1'b1));

        // Reset in the middle of a row-clear burst
        run_until_ready(TOTAL + 10);
        cycle(0, 1, 8'h0A);
        for (int i = 0; i < 20; i++) cycle(0, 0, 8'h00);
        cycle(1, 0, 8'h00);
        run_until_ready(TOTAL + 10);
        cycle(0, 1, 8'h5A);
        cycle(0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
